// File: rtl/sort_pkg.sv
// Shared types and sizing for the sorter consumer (stream transmitter).
package sort_pkg;
  localparam int unsigned N_CELLS = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = $clog2(N_CELLS);
  localparam int unsigned CNT_W   = 8;

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {IDLE, SEND, RESTART} tx_state_e;
endpackage

// File: rtl/sorted_stream_tx_if.sv
// Valid/ready element stream leaving the sorter consumer.
interface sorted_stream_tx_if;
  import sort_pkg::*;

  elem_t out_data;
  logic  out_valid;
  logic  out_ready;
  logic  out_last;
  idx_t  out_index;

  modport master (output out_data, output out_valid, output out_last, output out_index,
                  input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, input  out_index,
                  output out_ready);
endinterface

// File: rtl/sorted_capture_buf.sv
// Snapshot of the sorter array with an ascending/descending read mux.
module sorted_capture_buf
  import sort_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  elem_t [N_CELLS-1:0] data_i,
  input  idx_t                rd_idx_i,
  input  logic                rd_desc_i,
  output elem_t               rd_data_c
);

  elem_t [N_CELLS-1:0] mem_q;
  idx_t                sel_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (load_i) begin
      mem_q <= data_i;
    end
  end

  // Reads the post-edge contents so the caller can register the element.
  always_comb begin
    sel_c     = rd_desc_i ? (idx_t'(N_CELLS - 1) - rd_idx_i) : rd_idx_i;
    rd_data_c = load_i ? data_i[sel_c] : mem_q[sel_c];
  end

endmodule

// File: rtl/sorted_stream_tx.sv
// Captures the sorted array on sort_ready rising, streams it out, then requests a sorter restart.
module sorted_stream_tx
  import sort_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  elem_t [N_CELLS-1:0] sorted_array,
  input  logic                sort_ready,
  input  logic                desc_order,
  input  logic                flush,
  sorted_stream_tx_if.master  out_if,
  output logic                sorter_restart,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count
);

  localparam idx_t LAST_IDX = idx_t'(N_CELLS - 1);

  tx_state_e        state_q, state_d;
  idx_t             idx_q, idx_d;
  logic             desc_q, desc_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic             sort_ready_q;
  logic             load_c;
  logic             hs_c;
  elem_t            rd_data_c;

  logic             valid_q, last_q, restart_q, busy_q;
  idx_t             index_q;
  elem_t            data_q;

  sorted_capture_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_c),
    .data_i    (sorted_array),
    .rd_idx_i  (idx_d),
    .rd_desc_i (desc_d),
    .rd_data_c (rd_data_c)
  );

  assign hs_c = valid_q && out_if.out_ready;

  // Next-state: capture on a fresh sort_ready edge, flush beats the handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    desc_d  = desc_q;
    fc_d    = fc_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sort_ready && !sort_ready_q) begin
          load_c  = 1'b1;
          desc_d  = desc_order;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (flush) begin
          state_d = RESTART;
        end else if (hs_c) begin
          if (idx_q == LAST_IDX) begin
            state_d = RESTART;
            fc_d    = fc_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
      end
      RESTART: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      desc_q       <= 1'b0;
      fc_q         <= '0;
      sort_ready_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      index_q      <= '0;
      data_q       <= '0;
      restart_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      desc_q       <= desc_d;
      fc_q         <= fc_d;
      sort_ready_q <= sort_ready;
      valid_q      <= (state_d == SEND);
      last_q       <= (state_d == SEND) && (idx_d == LAST_IDX);
      index_q      <= (state_d == SEND) ? idx_d : '0;
      data_q       <= (state_d == SEND) ? rd_data_c : '0;
      restart_q    <= (state_d == RESTART);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign out_if.out_index = index_q;
  assign sorter_restart   = restart_q;
  assign busy             = busy_q;
  assign frame_count      = fc_q;

endmodule

// File: doc/sorted_stream_tx.md
Name: sorted_stream_tx

Overview:
- Consumer end of the linear sorter.
- Watches the sorter's ready flag and captures the full sorted array on its rising edge.
- Streams the array out one element per valid/ready handshake, in ascending or descending order.
- After the last element, pulses a restart request so the sorter can accept the next batch.

Parameters:
N_CELLS, 8, number of array elements (sorter cell count)
DATA_W, 8, element width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sorted_array  input  DATA_W x N_CELLS  parallel sorted data from sorter, index 0 = smallest
sort_ready  input  1  sorter done flag (level, stays high until sorter reset)
desc_order  input  1  0 = send index 0 first, 1 = send index N_CELLS-1 first; sampled at capture
flush  input  1  abort current frame
out_data  output  DATA_W  current element
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts when high with out_valid
out_last  output  1  high with final element of frame
out_index  output  clog2(N_CELLS)  position of current element within frame (0 = first sent)
sorter_restart  output  1  one-cycle pulse requesting sorter reset
busy  output  1  high in any state other than IDLE
frame_count  output  8  completed frames, wraps 255 -> 0

Behaviour:
- Reset, applied synchronously on the clk edge:
  - All outputs 0; state IDLE; element index 0.
  - sort_ready_q = 0; frame_count = 0; capture buffer = 0.
- sort_ready_q is sort_ready registered every cycle. Capture event = state IDLE && sort_ready && !sort_ready_q.
- FSM states: IDLE, SEND, RESTART.
- IDLE:
  - On a capture event, at that edge: buffer <- sorted_array; latch desc_order; idx <- 0; go to SEND.
  - out_valid rises the cycle after the edge where the rising sort_ready is first sampled (1-cycle latency).
  - A level-high sort_ready with no rising edge never triggers a capture.
- SEND:
  - out_valid = 1.
  - out_data = buffer[idx] when ascending, buffer[N_CELLS-1-idx] when descending.
  - out_index = idx; out_last = (idx == N_CELLS-1).
  - Handshake = out_valid && out_ready. On a handshake with idx < N_CELLS-1: idx <- idx+1.
  - On the handshake with out_last: go to RESTART and increment frame_count.
  - While out_valid && !out_ready: out_data, out_index and out_last hold stable indefinitely.
  - Changes to sorted_array or desc_order during SEND have no effect (data comes from the buffer only).
- flush during SEND:
  - Go to RESTART; out_valid is 0 from the next cycle; frame_count is NOT incremented.
  - flush in the same cycle as a handshake: the sink has taken that element, but flush wins, so no further elements are sent and no count is added, even on the last element.
- flush in IDLE or RESTART: ignored.
- RESTART:
  - sorter_restart = 1 for exactly one cycle; out_valid = 0.
  - Next state IDLE; idx <- 0.
  - Capture in IDLE again requires a fresh 0->1 edge of sort_ready.
- out_ready while out_valid = 0: ignored.
- Reset mid-frame: frame is abandoned, and no sorter_restart pulse is emitted (the sorter is reset by the system reset).
- Frame timing: minimum frame is N_CELLS handshake cycles plus 1 RESTART cycle. Back-to-back capture needs sort_ready to drop and rise again.
- busy = (state != IDLE).

Decomposition:
- Shared package sort_pkg:
  - DATA_W, N_CELLS, IDX_W = $clog2(N_CELLS).
  - typedef elem_t = logic [DATA_W-1:0].
  - typedef tx_state_e {IDLE, SEND, RESTART}.
- One sub-module, sorted_capture_buf:
  - Holds N_CELLS registers, loaded in one cycle on a load strobe.
  - Provides an order-selected read mux (idx, desc -> elem_t).
  - FSM, handshake, counters and edge detect stay in sorted_stream_tx.

Test Plan:
- Ascending, no backpressure: sorted_array = {3,9,17,40,41,88,120,255}, desc_order = 0, sort_ready rises, out_ready = 1.
  -> out_valid goes high 1 cycle after the edge; 8 consecutive beats 3,9,...,255.
  -> out_last only on 255; sorter_restart pulses 1 cycle after that beat; frame_count = 1.
- Descending: same array, desc_order = 1.
  -> Beats 255,120,88,41,40,17,9,3 with out_index 0..7.
  -> Changing desc_order and sorted_array mid-frame does not alter the output.
- Backpressure: out_ready low for 5 cycles on element index 2.
  -> out_data, out_index and out_last held constant for all 5 cycles; no element skipped or duplicated.
- Flush: flush asserted together with the handshake of index 4.
  -> No further beats; sorter_restart pulses the next cycle; frame_count is unchanged.
  -> Back in IDLE, sort_ready held high (no new edge) produces no capture.
- Reset mid-frame: reset asserted at index 5.
  -> Next cycle: out_valid = 0, busy = 0, frame_count = 0, and sorter_restart never asserts.
  -> A new sort_ready rise then starts a fresh frame from index 0.
